// File: rtl/aud_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : aud_pkg                                                  |
// | Description : Shared definitions for the audio player: default sample |
// |               and address widths, and the playback state encoding.     |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
package aud_pkg;

  localparam int c_DATA_W_DEF = 16;
  localparam int c_ADDR_W_DEF = 20;

  // Playback controller states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_HOLD  = 3'd2,
    ST_SEND  = 3'd3,
    ST_PAUSE = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/aud_player_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : aud_player_if                                            |
// | Description : Control, SRAM and codec signals of the audio player.     |
// |   i_daclrck   codec LR clock (high = right half)                       |
// |   i_start     start from idle / resume from pause                      |
// |   i_pause     request pause                                            |
// |   i_stop      abort playback                                           |
// |   i_end_addr  address of the last sample                               |
// |   i_sram_data sample at o_address (combinational SRAM read)            |
// |   o_address   SRAM read address                                        |
// |   o_aud_dacdat serial DAC data, MSB first                              |
// |   o_playing   high outside IDLE / PAUSE                                |
// |   o_done      one-cycle pulse after the last sample                    |
// |   Modports: slave = player side, master = controller/environment.      |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
interface aud_player_if #(
  parameter int DATA_W = aud_pkg::c_DATA_W_DEF,
  parameter int ADDR_W = aud_pkg::c_ADDR_W_DEF
) ();

  logic              i_daclrck;
  logic              i_start;
  logic              i_pause;
  logic              i_stop;
  logic [ADDR_W-1:0] i_end_addr;
  logic [DATA_W-1:0] i_sram_data;
  logic [ADDR_W-1:0] o_address;
  logic              o_aud_dacdat;
  logic              o_playing;
  logic              o_done;

  modport slave (
    input  i_daclrck, i_start, i_pause, i_stop, i_end_addr, i_sram_data,
    output o_address, o_aud_dacdat, o_playing, o_done
  );

  modport master (
    output i_daclrck, i_start, i_pause, i_stop, i_end_addr, i_sram_data,
    input  o_address, o_aud_dacdat, o_playing, o_done
  );

endinterface
`default_nettype wire

// File: rtl/aud_serializer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : aud_serializer                                           |
// | Description : Sample holding register and MSB-first bit shifter.       |
// |   i_clk/i_rst_n  bit clock, async active-low reset                     |
// |   i_clear        force line to 0 and abandon the current word          |
// |   i_latch        capture i_data (left-half start)                       |
// |   i_load         start shifting the held sample (right-half start)      |
// |   i_shift        advance one bit; drives 0 once all bits are out        |
// |   o_dat          registered serial data                                 |
// |   o_last         bit 0 is on the line / nothing left to shift           |
// |   Macro AUD_PLAYER_STEREO_EN: latch also starts a left-half copy.      |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module aud_serializer
  import aud_pkg::*;
#(
  parameter int DATA_W = c_DATA_W_DEF
) (
  input  wire              i_clk,
  input  wire              i_rst_n,
  input  wire              i_clear,
  input  wire              i_latch,
  input  wire [DATA_W-1:0] i_data,
  input  wire              i_load,
  input  wire              i_shift,
  output logic             o_dat,
  output logic             o_last
);

  localparam int                 c_CNT_W   = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_TOP = c_CNT_W'(DATA_W - 2);

  logic [DATA_W-1:0]  r_sample;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_dat;
  logic               r_last;

  assign o_dat  = r_dat;
  assign o_last = r_last;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sample <= '0;
      r_cnt    <= '0;
      r_dat    <= 1'b0;
      r_last   <= 1'b1;
    end else if (i_clear) begin
      r_dat  <= 1'b0;
      r_last <= 1'b1;
    end else if (i_latch) begin
      r_sample <= i_data;
`ifdef AUD_PLAYER_STEREO_EN
      // MSB comes straight from the SRAM bus so the left half starts on the edge.
      r_dat  <= i_data[DATA_W-1];
      r_cnt  <= c_CNT_TOP;
      r_last <= 1'b0;
`else
      r_dat  <= 1'b0;
      r_last <= 1'b1;
`endif
    end else if (i_load) begin
      r_dat  <= r_sample[DATA_W-1];
      r_cnt  <= c_CNT_TOP;
      r_last <= 1'b0;
    end else if (i_shift) begin
      if (r_last) begin
        r_dat <= 1'b0;
      end else begin
        r_dat  <= r_sample[r_cnt];
        r_last <= (r_cnt == '0);
        if (r_cnt != '0) begin
          r_cnt <= r_cnt - 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/aud_player.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : aud_player                                               |
// | Description : Plays samples from SRAM addresses 0..i_end_addr to a DAC |
// |               codec, one sample per LR-clock period (right channel).   |
// |   i_bclk   bit clock, sole clock                                       |
// |   i_rst_n  asynchronous active-low reset                               |
// |   bus      aud_player_if.slave (control, SRAM, codec data, status)     |
// |   Macro AUD_PLAYER_STEREO_EN: sample is also sent in the left half.    |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module aud_player
  import aud_pkg::*;
#(
  parameter int DATA_W = c_DATA_W_DEF,
  parameter int ADDR_W = c_ADDR_W_DEF
) (
  input  wire         i_bclk,
  input  wire         i_rst_n,
  aud_player_if.slave bus
);

  state_t            r_state;
  logic              r_lrc_d;
  logic              r_pause_pend;
  logic [ADDR_W-1:0] r_address;
  logic              r_playing;
  logic              r_done;

  logic w_fall;
  logic w_rise;
  logic w_clear;
  logic w_latch;
  logic w_load;
  logic w_shift;
  logic w_last;
  logic w_ser_dat;

  assign w_fall = r_lrc_d & ~bus.i_daclrck;
  assign w_rise = ~r_lrc_d & bus.i_daclrck;

  assign bus.o_address    = r_address;
  assign bus.o_playing    = r_playing;
  assign bus.o_done       = r_done;
  assign bus.o_aud_dacdat = w_ser_dat;

  // Serializer control mirrors the transition priorities of the FSM below.
  always_comb begin
    w_clear = 1'b0;
    w_latch = 1'b0;
    w_load  = 1'b0;
    w_shift = 1'b0;
    case (r_state)
      ST_FETCH: begin
        if (bus.i_stop || bus.i_pause) w_clear = 1'b1;
        else                           w_latch = w_fall;
      end
      ST_HOLD: begin
        if (bus.i_stop || bus.i_pause) w_clear = 1'b1;
        else if (w_rise)               w_load  = 1'b1;
        else                           w_shift = 1'b1;
      end
      ST_SEND: begin
        if (bus.i_stop) w_clear = 1'b1;
        else            w_shift = 1'b1;
      end
      default: w_clear = 1'b1;
    endcase
  end

  aud_serializer #(
    .DATA_W (DATA_W)
  ) u_serializer (
    .i_clk   (i_bclk),
    .i_rst_n (i_rst_n),
    .i_clear (w_clear),
    .i_latch (w_latch),
    .i_data  (bus.i_sram_data),
    .i_load  (w_load),
    .i_shift (w_shift),
    .o_dat   (w_ser_dat),
    .o_last  (w_last)
  );

  always_ff @(posedge i_bclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_lrc_d      <= 1'b0;
      r_pause_pend <= 1'b0;
      r_address    <= '0;
      r_playing    <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_lrc_d <= bus.i_daclrck;
      r_done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.i_start) begin
            r_state      <= ST_FETCH;
            r_address    <= '0;
            r_playing    <= 1'b1;
            r_pause_pend <= 1'b0;
          end
        end
        ST_FETCH, ST_HOLD: begin
          if (bus.i_stop) begin
            r_state   <= ST_IDLE;
            r_address <= '0;
            r_playing <= 1'b0;
          end else if (bus.i_pause) begin
            r_state   <= ST_PAUSE;
            r_playing <= 1'b0;
          end else if (r_state == ST_FETCH && w_fall) begin
            r_state <= ST_HOLD;
          end else if (r_state == ST_HOLD && w_rise) begin
            r_state <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (bus.i_stop) begin
            r_state      <= ST_IDLE;
            r_address    <= '0;
            r_playing    <= 1'b0;
            r_pause_pend <= 1'b0;
          end else begin
            if (bus.i_pause) r_pause_pend <= 1'b1;
            if (w_last) begin
              // '>=' keeps the address from running past a lowered end address.
              if (r_address >= bus.i_end_addr) begin
                r_state   <= ST_IDLE;
                r_address <= '0;
                r_playing <= 1'b0;
                r_done    <= 1'b1;
              end else begin
                r_address <= r_address + ADDR_W'(1);
                if (r_pause_pend || bus.i_pause) begin
                  r_state   <= ST_PAUSE;
                  r_playing <= 1'b0;
                end else begin
                  r_state <= ST_FETCH;
                end
              end
              r_pause_pend <= 1'b0;
            end
          end
        end
        ST_PAUSE: begin
          if (bus.i_stop) begin
            r_state   <= ST_IDLE;
            r_address <= '0;
          end else if (bus.i_start) begin
            r_state   <= ST_FETCH;
            r_playing <= 1'b1;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_address <= '0;
          r_playing <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aud_player.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_aud_player                                            |
// | Description : Self-checking bench for aud_player. A monitor rebuilds   |
// |               each serial word from the LR-clock edges and compares it |
// |               (with the address it was played from) against a queue of |
// |               expected words; scenario tasks check control behaviour.  |
// |   Macro AUD_PLAYER_STEREO_EN: left-half words are also expected.       |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_aud_player;

  localparam int DW = 16;
  localparam int AW = 20;
`ifdef AUD_PLAYER_STEREO_EN
  localparam bit STEREO = 1'b1;
`else
  localparam bit STEREO = 1'b0;
`endif

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  logic clk;
  logic rst_n;
  logic [DW-1:0] mem [0:15];
  exp_t exp_q [$];

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  int mon_k    = 1000;
  logic mon_d  = 1'b0;
  bit   mon_en = 1'b1;
  logic [DW-1:0] mon_word = '0;
  logic [AW-1:0] mon_addr = '0;

  aud_player_if #(.DATA_W(DW), .ADDR_W(AW)) bus_if ();

  aud_player #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .i_bclk  (clk),
    .i_rst_n (rst_n),
    .bus     (bus_if)
  );

  assign bus_if.i_sram_data = mem[bus_if.o_address[3:0]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // LR clock: 24 bit clocks per half.
  initial begin
    bus_if.i_daclrck = 1'b0;
    forever begin
      repeat (24) @(negedge clk);
      bus_if.i_daclrck = ~bus_if.i_daclrck;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // Word monitor and scoreboard.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst_n !== 1'b1) begin
      mon_d = 1'b0;
      mon_k = 1000;
    end else begin
      if (bus_if.i_daclrck !== mon_d) mon_k = 0;
      else if (mon_k < 1000)          mon_k++;
      mon_d = bus_if.i_daclrck;
      if (bus_if.o_done === 1'b1) done_cnt++;
      if (mon_k < DW && (mon_d == 1'b1 || STEREO)) begin
        if (mon_k == 0) begin
          mon_word = '0;
          mon_addr = bus_if.o_address;
        end
        mon_word = {mon_word[DW-2:0], bus_if.o_aud_dacdat};
        if (mon_k == DW - 1 && mon_en && mon_word != '0) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_word unexpected word %h from addr %0d", mon_word, mon_addr);
          end else begin
            e = exp_q.pop_front();
            if (mon_addr !== e.addr || mon_word !== e.data) begin
              errors++;
              $display("FAIL sb_word got addr %0d data %h, want addr %0d data %h",
                       mon_addr, mon_word, e.addr, e.data);
            end
          end
        end
      end else if (mon_en) begin
        checks++;
        if (bus_if.o_aud_dacdat !== 1'b0) begin
          errors++;
          $display("FAIL line_zero dacdat %b, want 0 (lrck %b cycle %0d)",
                   bus_if.o_aud_dacdat, mon_d, mon_k);
        end
      end
    end
  end

  task automatic push_exp(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    e.addr = a;
    e.data = d;
    if (STEREO) exp_q.push_back(e);
    exp_q.push_back(e);
  endtask

  task automatic pulse_start();
    bus_if.i_start = 1'b1;
    @(negedge clk);
    bus_if.i_start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output bit seen, output int ones,
                           output logic [AW-1:0] max_addr);
    seen = 1'b0;
    ones = 0;
    max_addr = '0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (bus_if.o_aud_dacdat === 1'b1) ones++;
      if (bus_if.o_address > max_addr) max_addr = bus_if.o_address;
      if (bus_if.o_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  // Waits for cycle k of a right half while address a is playing.
  task automatic wait_send(input logic [AW-1:0] a, input int k, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (bus_if.o_address == a && mon_k == k && mon_d == 1'b1 && bus_if.o_playing == 1'b1) begin
        hit = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus_if.i_start    = 1'b0;
    bus_if.i_pause    = 1'b0;
    bus_if.i_stop     = 1'b0;
    bus_if.i_end_addr = '0;
    for (int i = 0; i < 16; i++) mem[i] = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus_if.o_address !== '0) begin errors++; $display("FAIL reset_address got %h want 0", bus_if.o_address); end
    checks++; if (bus_if.o_aud_dacdat !== 1'b0) begin errors++; $display("FAIL reset_dacdat got %b want 0", bus_if.o_aud_dacdat); end
    checks++; if (bus_if.o_playing !== 1'b0) begin errors++; $display("FAIL reset_playing got %b want 0", bus_if.o_playing); end
    checks++; if (bus_if.o_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", bus_if.o_done); end
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    checks++; if (bus_if.o_playing !== 1'b0) begin errors++; $display("FAIL idle_playing got %b want 0", bus_if.o_playing); end
  endtask

  task automatic test_play3();
    bit seen; int ones; logic [AW-1:0] mx; int d0;
    mem[0] = 16'hA5C3; mem[1] = 16'h8001; mem[2] = 16'h7FFE;
    bus_if.i_end_addr = 20'd2;
    push_exp(20'd0, 16'hA5C3);
    push_exp(20'd1, 16'h8001);
    push_exp(20'd2, 16'h7FFE);
    d0 = done_cnt;
    pulse_start();
    checks++; if (bus_if.o_playing !== 1'b1) begin errors++; $display("FAIL play3_playing got %b want 1", bus_if.o_playing); end
    wait_done(600, seen, ones, mx);
    checks++; if (!seen) begin errors++; $display("FAIL play3_done got none want pulse"); end
    checks++; if (bus_if.o_address !== '0) begin errors++; $display("FAIL play3_addr_after got %0d want 0", bus_if.o_address); end
    checks++; if (bus_if.o_playing !== 1'b0) begin errors++; $display("FAIL play3_playing_after got %b want 0", bus_if.o_playing); end
    checks++; if (mx !== 20'd2) begin errors++; $display("FAIL play3_max_addr got %0d want 2", mx); end
    checks++; if (ones != 24 * (STEREO ? 2 : 1)) begin errors++; $display("FAIL play3_ones got %0d want %0d", ones, 24 * (STEREO ? 2 : 1)); end
    repeat (60) @(negedge clk);
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL play3_done_cycles got %0d want 1", done_cnt - d0); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL play3_words_left got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_pause();
    bit hit; bit seen; int ones; logic [AW-1:0] mx;
    for (int i = 0; i < 10; i++) mem[i] = 16'h1111 * DW'(i + 1);
    bus_if.i_end_addr = 20'd9;
    for (int i = 0; i <= 5; i++) push_exp(AW'(i), mem[i]);
    pulse_start();
    wait_send(20'd5, 5, hit);
    checks++; if (!hit) begin errors++; $display("FAIL pause_reach got timeout want send at addr 5"); end
    bus_if.i_pause = 1'b1;
    @(negedge clk);
    bus_if.i_pause = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus_if.o_playing === 1'b0) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!hit) begin errors++; $display("FAIL pause_enter got timeout want playing 0"); end
    checks++; if (bus_if.o_address !== 20'd6) begin errors++; $display("FAIL pause_addr got %0d want 6", bus_if.o_address); end
    checks++; if (bus_if.o_aud_dacdat !== 1'b0) begin errors++; $display("FAIL pause_dacdat got %b want 0", bus_if.o_aud_dacdat); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL pause_words_left got %0d want 0", exp_q.size()); end
    repeat (100) @(negedge clk);
    checks++; if (bus_if.o_address !== 20'd6 || bus_if.o_playing !== 1'b0) begin
      errors++; $display("FAIL pause_hold got addr %0d playing %b want 6 0", bus_if.o_address, bus_if.o_playing);
    end
    for (int i = 6; i <= 9; i++) push_exp(AW'(i), mem[i]);
    pulse_start();
    wait_done(1000, seen, ones, mx);
    checks++; if (!seen) begin errors++; $display("FAIL resume_done got none want pulse"); end
    checks++; if (mx !== 20'd9) begin errors++; $display("FAIL resume_max_addr got %0d want 9", mx); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL resume_words_left got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_stop_start();
    bit hit; int d0; int bad;
    bus_if.i_end_addr = 20'd9;
    push_exp(20'd0, mem[0]);
    pulse_start();
    wait_send(20'd1, 5, hit);
    checks++; if (!hit) begin errors++; $display("FAIL stop_reach got timeout want send at addr 1"); end
    mon_en = 1'b0;
    d0 = done_cnt;
    bus_if.i_stop  = 1'b1;
    bus_if.i_start = 1'b1;
    @(negedge clk);
    bus_if.i_stop  = 1'b0;
    bus_if.i_start = 1'b0;
    checks++; if (bus_if.o_playing !== 1'b0) begin errors++; $display("FAIL stop_playing got %b want 0", bus_if.o_playing); end
    checks++; if (bus_if.o_aud_dacdat !== 1'b0) begin errors++; $display("FAIL stop_dacdat got %b want 0", bus_if.o_aud_dacdat); end
    checks++; if (bus_if.o_address !== '0) begin errors++; $display("FAIL stop_addr got %0d want 0", bus_if.o_address); end
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus_if.o_aud_dacdat !== 1'b0 || bus_if.o_playing !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL stop_quiet got %0d active cycles want 0", bad); end
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL stop_no_done got %0d pulses want 0", done_cnt - d0); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL stop_words_left got %0d want 0", exp_q.size()); end
    mon_en = 1'b1;
  endtask

  task automatic test_single();
    bit seen; int ones; logic [AW-1:0] mx; int d0;
    mem[0] = 16'hFFFF;
    bus_if.i_end_addr = '0;
    push_exp(20'd0, 16'hFFFF);
    d0 = done_cnt;
    pulse_start();
    wait_done(400, seen, ones, mx);
    checks++; if (!seen) begin errors++; $display("FAIL single_done got none want pulse"); end
    checks++; if (ones != 16 * (STEREO ? 2 : 1)) begin errors++; $display("FAIL single_ones got %0d want %0d", ones, 16 * (STEREO ? 2 : 1)); end
    checks++; if (mx !== '0) begin errors++; $display("FAIL single_max_addr got %0d want 0", mx); end
    checks++; if (bus_if.o_playing !== 1'b0) begin errors++; $display("FAIL single_playing got %b want 0", bus_if.o_playing); end
    repeat (5) @(negedge clk);
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL single_done_cycles got %0d want 1", done_cnt - d0); end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL single_words_left got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_lr_halves();
    bit seen; int ones; logic [AW-1:0] mx;
    mem[0] = 16'h1234;
    bus_if.i_end_addr = '0;
    push_exp(20'd0, 16'h1234);
    pulse_start();
    wait_done(400, seen, ones, mx);
    checks++; if (!seen) begin errors++; $display("FAIL lr_done got none want pulse"); end
    checks++; if (ones != 5 * (STEREO ? 2 : 1)) begin errors++; $display("FAIL lr_ones got %0d want %0d", ones, 5 * (STEREO ? 2 : 1)); end
    repeat (60) @(negedge clk);
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL lr_words_left got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid();
    bit hit; int bad;
    mem[0] = 16'hA5C3; mem[1] = 16'h8001; mem[2] = 16'h7FFE;
    bus_if.i_end_addr = 20'd2;
    mon_en = 1'b0;
    pulse_start();
    wait_send(20'd1, 5, hit);
    checks++; if (!hit) begin errors++; $display("FAIL rstmid_reach got timeout want send at addr 1"); end
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (bus_if.o_address !== '0) begin errors++; $display("FAIL rstmid_addr got %0d want 0", bus_if.o_address); end
    checks++; if (bus_if.o_aud_dacdat !== 1'b0) begin errors++; $display("FAIL rstmid_dacdat got %b want 0", bus_if.o_aud_dacdat); end
    checks++; if (bus_if.o_playing !== 1'b0) begin errors++; $display("FAIL rstmid_playing got %b want 0", bus_if.o_playing); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 150; i++) begin
      @(negedge clk);
      if (bus_if.o_aud_dacdat !== 1'b0 || bus_if.o_playing !== 1'b0 || bus_if.o_done !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL rstmid_quiet got %0d active cycles want 0", bad); end
    mon_en = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus_if.i_start    = 1'b0;
    bus_if.i_pause    = 1'b0;
    bus_if.i_stop     = 1'b0;
    bus_if.i_end_addr = '0;
    test_reset();
    test_play3();
    test_pause();
    test_stop_start();
    test_single();
    test_lr_halves();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
